// File: rtl/generic_pack.sv
// Shared types for the RGB pixel-checking datapath: pixel struct, checker
// state encoding and readback field offsets.
package generic_pack;

    localparam int RGB_DATA_W   = 8;
    localparam int RGB_PIX_W    = 3 * RGB_DATA_W;
    localparam int MM2S_RGB_LSB = 0;

    typedef struct packed {
        logic [RGB_DATA_W-1:0] red;
        logic [RGB_DATA_W-1:0] green;
        logic [RGB_DATA_W-1:0] blue;
    } rgb_pix_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } chk_state_t;

    // Flatten a pixel into the {R,G,B} order used by the readback beat.
    function automatic logic [RGB_PIX_W-1:0] pix_to_word(input rgb_pix_t p);
        return {p.red, p.green, p.blue};
    endfunction

endpackage

// File: rtl/rgb_pix_fifo.sv
// Synchronous pixel FIFO with flush; a push is accepted while full when a pop
// happens in the same cycle.
module rgb_pix_fifo
    import generic_pack::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clkmm,
    input  logic     reset,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  rgb_pix_t wr_pix,
    output rgb_pix_t rd_pix,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    rgb_pix_t      mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against the current fill level.
    always_comb begin
        full      = (count_r == DEPTH_C);
        empty     = (count_r == '0);
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        rd_pix    = mem_r[rd_ptr_r];
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clkmm) begin
        if (push_ok_s && !reset && !flush) begin
            mem_r[wr_ptr_r] <= wr_pix;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clkmm) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rgb_frame_check_ctrl.sv
// Per-frame RGB compare sequencer: buffers camera pixels and checks MM2S
// readback beats against them. Optional first-mismatch log: RGB_CHK_ERR_LOG_EN.
module rgb_frame_check_ctrl
    import generic_pack::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_PIXELS = 1024,
    parameter int CNT_W        = 16
) (
    input  logic              clkmm,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              valid,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic              m_axis_mm2s_tvalid,
    input  logic [31:0]       m_axis_mm2s_tdata,
    output logic              m_axis_mm2s_tready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              overflow,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [CNT_W-1:0]  pix_count
`ifdef RGB_CHK_ERR_LOG_EN
    ,
    output logic [CNT_W-1:0]  err_index,
    output logic [23:0]       err_exp,
    output logic [23:0]       err_got
`endif
);

    localparam logic [CNT_W:0] FRAME_N = (CNT_W+1)'(FRAME_PIXELS);

    chk_state_t      state_r;
    chk_state_t      state_nx_s;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic            overflow_r;
    logic [CNT_W-1:0] pix_count_r;
    logic [CNT_W-1:0] mismatch_count_r;
    logic [CNT_W:0]  pushed_r;

    rgb_pix_t        cam_pix_s;
    rgb_pix_t        head_pix_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_push_s;
    logic            fifo_flush_s;
    logic            in_check_s;
    logic            tready_s;
    logic            hs_s;
    logic            cam_req_s;
    logic            ovf_evt_s;
    logic            mism_s;
    logic            last_beat_s;
    logic [RGB_PIX_W-1:0] exp_word_s;
    logic [RGB_PIX_W-1:0] got_word_s;
    logic            unused_tdata_s;

    assign unused_tdata_s = ^m_axis_mm2s_tdata[31:24];

    // Handshake, push qualification and compare for the current cycle.
    always_comb begin
        cam_pix_s.red   = RGB_DATA_W'(iRed);
        cam_pix_s.green = RGB_DATA_W'(iGreen);
        cam_pix_s.blue  = RGB_DATA_W'(iBlue);
        in_check_s   = (state_r == CHECK);
        tready_s     = in_check_s && !fifo_empty_s;
        hs_s         = m_axis_mm2s_tvalid && tready_s;
        cam_req_s    = in_check_s && valid && (pushed_r < FRAME_N);
        // A pop in the same cycle frees the slot, so full alone is not an overflow.
        ovf_evt_s    = cam_req_s && fifo_full_s && !hs_s;
        fifo_push_s  = cam_req_s && !ovf_evt_s && !abort;
        fifo_flush_s = abort || (state_r == ARM);
        exp_word_s   = pix_to_word(head_pix_s);
        got_word_s   = m_axis_mm2s_tdata[MM2S_RGB_LSB +: RGB_PIX_W];
        mism_s       = hs_s && (got_word_s != exp_word_s);
        last_beat_s  = hs_s && (({1'b0, pix_count_r} + (CNT_W+1)'(1'b1)) == FRAME_N);
    end

    rgb_pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkmm  (clkmm),
        .reset  (reset),
        .flush  (fifo_flush_s),
        .push   (fifo_push_s),
        .pop    (hs_s),
        .wr_pix (cam_pix_s),
        .rd_pix (head_pix_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Next-state decode; abort overrides everything, overflow beats frame end.
    always_comb begin
        state_nx_s = state_r;
        if (abort) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE, ERR: state_nx_s = start ? ARM : state_r;
                ARM:             state_nx_s = CHECK;
                CHECK: begin
                    if (ovf_evt_s) begin
                        state_nx_s = ERR;
                    end else if (last_beat_s) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = CHECK;
                    end
                end
                default:         state_nx_s = IDLE;
            endcase
        end
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clkmm) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ARM) || (state_nx_s == CHECK);
            done_r  <= (state_nx_s == DONE) || (state_nx_s == ERR);
        end
    end

    // Run counters and verdict; abort freezes them for inspection.
    always_ff @(posedge clkmm) begin
        if (reset) begin
            pushed_r         <= '0;
            pix_count_r      <= '0;
            mismatch_count_r <= '0;
            overflow_r       <= 1'b0;
            pass_r           <= 1'b0;
        end else if (abort) begin
            pushed_r <= '0;
        end else if (state_r == ARM) begin
            pushed_r         <= '0;
            pix_count_r      <= '0;
            mismatch_count_r <= '0;
            overflow_r       <= 1'b0;
            pass_r           <= 1'b0;
        end else if (in_check_s) begin
            if (fifo_push_s) begin
                pushed_r <= pushed_r + (CNT_W+1)'(1'b1);
            end
            if (hs_s) begin
                pix_count_r <= pix_count_r + CNT_W'(1'b1);
            end
            if (mism_s && (mismatch_count_r != {CNT_W{1'b1}})) begin
                mismatch_count_r <= mismatch_count_r + CNT_W'(1'b1);
            end
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
                pass_r     <= 1'b0;
            end else if (last_beat_s) begin
                pass_r <= (mismatch_count_r == '0) && !mism_s && !overflow_r;
            end
        end
    end

`ifdef RGB_CHK_ERR_LOG_EN
    logic             err_seen_r;
    logic [CNT_W-1:0] err_index_r;
    logic [23:0]      err_exp_r;
    logic [23:0]      err_got_r;

    // Capture the first mismatching beat of a run.
    always_ff @(posedge clkmm) begin
        if (reset || (!abort && (state_r == ARM))) begin
            err_seen_r  <= 1'b0;
            err_index_r <= '0;
            err_exp_r   <= 24'h000000;
            err_got_r   <= 24'h000000;
        end else if (!abort && mism_s && !err_seen_r) begin
            err_seen_r  <= 1'b1;
            err_index_r <= pix_count_r;
            err_exp_r   <= 24'(exp_word_s);
            err_got_r   <= 24'(got_word_s);
        end
    end

    assign err_index = err_index_r;
    assign err_exp   = err_exp_r;
    assign err_got   = err_got_r;
`endif

    assign m_axis_mm2s_tready = tready_s;
    assign busy               = busy_r;
    assign done               = done_r;
    assign pass               = pass_r;
    assign overflow           = overflow_r;
    assign mismatch_count     = mismatch_count_r;
    assign pix_count          = pix_count_r;

endmodule
